sdx_kernel_addwm_example_wm_embed: RTL and testbench

Streaming watermark-embed stage that consumes the 512-bit beat stream produced by the kernel's AXI read stage (the `wm_to_kernel_*` stream). Per job it adds a 32-bit constant to every lane and XORs a watermark key into lane 0 of periodic beats. It forwards the result as an AXI4-Stream master and pulses `ap_done` once the last beat has left. Single clock, two-stage ready/valid pipeline, full throughput of one beat per cycle.

---
 rtl/sdx_kernel_addwm_example_wm_pkg.sv | 41 ++++
 rtl/sdx_kernel_addwm_example_wm_embed_if.sv | 12 +
 rtl/sdx_kernel_addwm_example_wm_lane_add.sv | 15 +
 rtl/sdx_kernel_addwm_example_wm_embed.sv | 145 ++++++++++++++
 tb/tb_sdx_kernel_addwm_example_wm_embed.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdx_kernel_addwm_example_wm_pkg.sv
// Shared types and helpers for the watermark-embed stage: FSM states,
// lane-count helper and the lane XOR reduction used for the output checksum.
package sdx_kernel_addwm_example_wm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wm_state_e;

  localparam int LP_DEF_DATA_WIDTH = 512;
  localparam int LP_DEF_LANE_WIDTH = 32;
  localparam int LP_NUM_LANES      = LP_DEF_DATA_WIDTH / LP_DEF_LANE_WIDTH;

  // Upper bounds for the generic reduction; callers zero-extend into these.
  localparam int LP_MAX_DATA_WIDTH = 1024;
  localparam int LP_MAX_LANE_WIDTH = 64;

  function automatic int num_lanes(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

  // XOR of every lane_width-bit lane of data; unused high lanes must be zero.
  function automatic logic [LP_MAX_LANE_WIDTH-1:0] lane_xor_reduce(
    input logic [LP_MAX_DATA_WIDTH-1:0] data,
    input int                           lane_width
  );
    logic [LP_MAX_LANE_WIDTH-1:0] acc;
    logic [LP_MAX_LANE_WIDTH-1:0] mask;
    logic [LP_MAX_DATA_WIDTH-1:0] sh;
    acc  = '0;
    mask = (lane_width >= LP_MAX_LANE_WIDTH) ? '1
         : (LP_MAX_LANE_WIDTH'(1) << lane_width) - LP_MAX_LANE_WIDTH'(1);
    for (int i = 0; i < LP_MAX_DATA_WIDTH; i += lane_width) begin
      sh  = data >> i;
      acc = acc ^ (sh[LP_MAX_LANE_WIDTH-1:0] & mask);
    end
    return acc;
  endfunction

endpackage

// File: rtl/sdx_kernel_addwm_example_wm_embed_if.sv
// AXI4-Stream beat bundle (valid/ready/data/last) used on both sides of the stage.
interface sdx_kernel_addwm_example_wm_embed_if #(
  parameter int DW = 512
) ();
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input  tready);
  modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/sdx_kernel_addwm_example_wm_lane_add.sv
// Purely combinational lane-wise adder: each lane gets the same addend, carry
// out of each lane is discarded.
module sdx_kernel_addwm_example_wm_lane_add #(
  parameter int C_DATA_WIDTH = 512,
  parameter int C_LANE_WIDTH = 32
) (
  input  logic [C_DATA_WIDTH-1:0] data,
  input  logic [C_LANE_WIDTH-1:0] addend,
  output logic [C_DATA_WIDTH-1:0] sum
);
  for (genvar i = 0; i < C_DATA_WIDTH / C_LANE_WIDTH; i++) begin : g_lane
    assign sum[i*C_LANE_WIDTH +: C_LANE_WIDTH] =
      data[i*C_LANE_WIDTH +: C_LANE_WIDTH] + addend;
  end
endmodule

// File: rtl/sdx_kernel_addwm_example_wm_embed.sv
// Watermark-embed stage: adds a constant to every lane, XORs a key into lane 0
// of every period-th beat, two-stage ready/valid pipeline at one beat per cycle.
module sdx_kernel_addwm_example_wm_embed
  import sdx_kernel_addwm_example_wm_pkg::*;
#(
  parameter int C_DATA_WIDTH = 512,
  parameter int C_LANE_WIDTH = 32,
  parameter int C_CNT_WIDTH  = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     ap_start,
  output logic                     ap_done,
  output logic                     ap_idle,
  input  logic [C_LANE_WIDTH-1:0]  ctrl_constant,
  input  logic [C_LANE_WIDTH-1:0]  ctrl_wm_key,
  input  logic [C_CNT_WIDTH-1:0]   ctrl_wm_period,
  sdx_kernel_addwm_example_wm_embed_if.slave  s_axis,
  sdx_kernel_addwm_example_wm_embed_if.master m_axis,
  output logic [C_CNT_WIDTH-1:0]   stat_beats,
  output logic [C_LANE_WIDTH-1:0]  stat_checksum
);
  localparam int LP_LANES = num_lanes(C_DATA_WIDTH, C_LANE_WIDTH);

  wm_state_e                 state;
  logic [C_LANE_WIDTH-1:0]   constant_q;
  logic [C_LANE_WIDTH-1:0]   key_q;
  logic [C_CNT_WIDTH-1:0]    period_q;
  logic [C_CNT_WIDTH-1:0]    phase_q;   // beats left until the next embed

  logic                      v1;
  logic                      last1;
  logic                      emb1;
  logic [C_DATA_WIDTH-1:0]   d1;
  logic [C_DATA_WIDTH-1:0]   d1_emb;
  logic [C_DATA_WIDTH-1:0]   sum;

  logic                      ld1;
  logic                      ld2;
  logic                      s_acc;
  logic                      m_hs;

  logic [LP_MAX_DATA_WIDTH-1:0] out_ext;
  logic [LP_MAX_LANE_WIDTH-1:0] out_xor_full;
  logic                         out_xor_unused;

  sdx_kernel_addwm_example_wm_lane_add #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_LANE_WIDTH (C_LANE_WIDTH)
  ) u_lane_add (
    .data   (s_axis.tdata),
    .addend (constant_q),
    .sum    (sum)
  );

  assign ld2           = !m_axis.tvalid || m_axis.tready;
  assign ld1           = !v1 || ld2;
  assign s_axis.tready = (state == ST_RUN) && ld1;
  assign s_acc         = s_axis.tvalid && s_axis.tready;
  assign m_hs          = m_axis.tvalid && m_axis.tready;

  // NOTE: every signal assigned in always_comb gets a default first so that no
  // path leaves it unassigned and a latch is inferred.
  always_comb begin
    d1_emb = d1;
    if (emb1) d1_emb[C_LANE_WIDTH-1:0] = d1[C_LANE_WIDTH-1:0] ^ key_q;
  end

  always_comb begin
    out_ext                   = '0;
    out_ext[C_DATA_WIDTH-1:0] = m_axis.tdata;
  end

  assign out_xor_full   = lane_xor_reduce(out_ext, C_LANE_WIDTH);
  assign out_xor_unused = ^out_xor_full;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of every other, independent of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= ST_IDLE;
      ap_idle       <= 1'b1;
      ap_done       <= 1'b0;
      constant_q    <= '0;
      key_q         <= '0;
      period_q      <= '0;
      phase_q       <= '0;
      v1            <= 1'b0;
      last1         <= 1'b0;
      emb1          <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tlast  <= 1'b0;
      stat_beats    <= '0;
      stat_checksum <= '0;
    end else begin
      ap_done <= 1'b0;
      case (state)
        ST_IDLE: if (ap_start) begin
          constant_q    <= ctrl_constant;
          key_q         <= ctrl_wm_key;
          period_q      <= ctrl_wm_period;
          phase_q       <= '0;
          stat_beats    <= '0;
          stat_checksum <= '0;
          ap_idle       <= 1'b0;
          state         <= ST_RUN;
        end
        ST_RUN: if (s_acc && s_axis.tlast) state <= ST_DRAIN;
        ST_DRAIN: if (m_hs && m_axis.tlast) begin
          ap_done <= 1'b1;
          ap_idle <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (ld1) v1 <= s_acc;
      if (s_acc) begin
        last1      <= s_axis.tlast;
        emb1       <= (period_q != '0) && (phase_q == '0);
        phase_q    <= (phase_q == '0) ? period_q - C_CNT_WIDTH'(1)
                                      : phase_q - C_CNT_WIDTH'(1);
        stat_beats <= stat_beats + C_CNT_WIDTH'(1);
      end

      if (ld2) begin
        m_axis.tvalid <= v1;
        if (v1) begin
          m_axis.tdata <= d1_emb;
          m_axis.tlast <= last1;
        end
      end

      if (m_hs) stat_checksum <= stat_checksum ^ out_xor_full[C_LANE_WIDTH-1:0];
    end
  end

  // NOTE: stage-1 data is qualified by v1, so it needs no reset; leaving it out
  // keeps the reset net off the wide datapath flops.
  always_ff @(posedge aclk) begin
    if (s_acc) d1 <= sum;
  end

endmodule

// File: tb/tb_sdx_kernel_addwm_example_wm_embed.sv
// Self-checking bench: randomized stream traffic against a behavioural model of
// the add/embed rule, plus hand-computed expectations for the directed jobs.
module tb_sdx_kernel_addwm_example_wm_embed;
  localparam int DW = 512;
  localparam int LW = 32;
  localparam int CW = 32;
  localparam int NL = DW / LW;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          ap_start = 1'b0;
  logic          ap_done;
  logic          ap_idle;
  logic [LW-1:0] ctrl_constant = '0;
  logic [LW-1:0] ctrl_wm_key = '0;
  logic [CW-1:0] ctrl_wm_period = '0;
  logic [CW-1:0] stat_beats;
  logic [LW-1:0] stat_checksum;

  sdx_kernel_addwm_example_wm_embed_if #(.DW(DW)) s_if ();
  sdx_kernel_addwm_example_wm_embed_if #(.DW(DW)) m_if ();

  sdx_kernel_addwm_example_wm_embed #(
    .C_DATA_WIDTH (DW),
    .C_LANE_WIDTH (LW),
    .C_CNT_WIDTH  (CW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .ap_start       (ap_start),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .ctrl_constant  (ctrl_constant),
    .ctrl_wm_key    (ctrl_wm_key),
    .ctrl_wm_period (ctrl_wm_period),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .stat_beats     (stat_beats),
    .stat_checksum  (stat_checksum)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state for the current job
  logic [LW-1:0] job_const, job_key;
  logic [CW-1:0] job_period;
  int unsigned   job_idx;
  logic [LW-1:0] exp_csum;
  beat_t         exp_q[$];
  logic [DW-1:0] out_log[$];
  int            done_cnt = 0;
  int            cyc = 0;
  int            first_acc_cyc, first_vld_cyc;
  int            ready_mode = 0;  // 0: always ready, 1: 30% ready, 2: never ready

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_out(input logic [DW-1:0] din, input int unsigned idx);
    logic [DW-1:0] r;
    for (int l = 0; l < NL; l++) r[l*LW +: LW] = din[l*LW +: LW] + job_const;
    if (job_period != 0 && (idx % job_period) == 0) r[LW-1:0] = r[LW-1:0] ^ job_key;
    return r;
  endfunction

  function automatic logic [LW-1:0] xor_lanes(input logic [DW-1:0] d);
    logic [LW-1:0] x = '0;
    for (int l = 0; l < NL; l++) x ^= d[l*LW +: LW];
    return x;
  endfunction

  function automatic logic [DW-1:0] gen_data(input int pattern, input int idx);
    logic [DW-1:0] d = '0;
    case (pattern)
      1:       d[LW-1:0] = LW'(idx);
      2:       d = '1;
      default: for (int l = 0; l < NL; l++) d[l*LW +: LW] = $urandom;
    endcase
    return d;
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  // Output ready driver
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        1:       m_if.tready = ($urandom_range(0, 99) < 30);
        2:       m_if.tready = 1'b0;
        default: m_if.tready = 1'b1;
      endcase
    end
  end

  // Model update and compare, sampled mid-cycle
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", DW'(m_if.tvalid), DW'(1));
        check("stall_data", m_if.tdata, prev_data);
        check("stall_last", DW'(m_if.tlast), DW'(prev_last));
      end
      if (s_if.tvalid && s_if.tready) begin
        if (job_idx == 0) first_acc_cyc = cyc;
        exp_q.push_back('{data: model_out(s_if.tdata, job_idx), last: s_if.tlast});
        job_idx++;
      end
      if (m_if.tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_if.tdata, '0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", m_if.tdata, e.data);
          check("out_last", DW'(m_if.tlast), DW'(e.last));
          exp_csum ^= xor_lanes(e.data);
          out_log.push_back(m_if.tdata);
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
      if (ap_done) done_cnt++;
    end
  end

  task automatic start_job(input logic [LW-1:0] c, input logic [LW-1:0] k, input logic [CW-1:0] p);
    check("start_idle", DW'(ap_idle), DW'(1));
    job_const = c; job_key = k; job_period = p;
    job_idx = 0; exp_csum = '0; out_log.delete();
    first_vld_cyc = -1;
    ap_start = 1'b1; ctrl_constant = c; ctrl_wm_key = k; ctrl_wm_period = p;
    @(posedge aclk); #1;
    ap_start = 1'b0;
    ctrl_constant = $urandom; ctrl_wm_key = $urandom; ctrl_wm_period = $urandom;
  endtask

  task automatic send_beats(input int n, input int pattern, input bit with_last, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      int budget;
      while ($urandom_range(0, 99) < gap_pct) begin
        @(posedge aclk); #1;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = gen_data(pattern, i);
      s_if.tlast  = with_last && (i == n - 1);
      budget = 0;
      forever begin
        @(negedge aclk);
        if (s_if.tready) break;
        budget++;
        if (budget > 3000) begin
          $display("FAIL send_timeout: beat %0d never accepted", i);
          $fatal(1, "input stream stuck");
        end
      end
      @(posedge aclk); #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int budget = 0;
    while (done_cnt == d0 && budget < 3000) begin
      @(posedge aclk); #1;
      budget++;
    end
    check({name, "_done_seen"}, DW'(done_cnt - d0), DW'(1));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_s_tready"}, DW'(s_if.tready), '0);
    check({name, "_m_tvalid"}, DW'(m_if.tvalid), '0);
    check({name, "_m_tdata"}, m_if.tdata, '0);
    check({name, "_m_tlast"}, DW'(m_if.tlast), '0);
    check({name, "_ap_done"}, DW'(ap_done), '0);
    check({name, "_ap_idle"}, DW'(ap_idle), DW'(1));
    check({name, "_stat_beats"}, DW'(stat_beats), '0);
    check({name, "_stat_checksum"}, DW'(stat_checksum), '0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [DW-1:0] exp1;
    logic [LW-1:0] lit2 [8] = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd5, 32'd6, 32'd7};

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    job_idx = 0; exp_csum = '0; first_vld_cyc = -1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    check_reset_values("reset");

    // One-beat job: all-ones + 1 wraps to 0, then key lands in lane 0
    start_job(32'd1, 32'hA5A5A5A5, 32'd1);
    d0 = done_cnt;
    send_beats(1, 2, 1'b1, 0);
    wait_done("one_beat");
    exp1 = '0; exp1[31:0] = 32'hA5A5A5A5;
    check("one_beat_out", (out_log.size() == 1) ? out_log[0] : '1, exp1);
    check("one_beat_stat_beats", DW'(stat_beats), DW'(1));
    check("one_beat_checksum", DW'(stat_checksum), DW'(32'hA5A5A5A5));
    repeat (3) @(posedge aclk); #1;
    check("one_beat_done_once", DW'(done_cnt - d0), DW'(1));

    // Eight-beat job, period 4, key 1
    start_job(32'd0, 32'd1, 32'd4);
    send_beats(8, 1, 1'b1, 0);
    wait_done("eight_beat");
    check("eight_beat_count", DW'(out_log.size()), DW'(8));
    for (int i = 0; i < 8 && i < out_log.size(); i++)
      check($sformatf("eight_beat_lane0_%0d", i), DW'(out_log[i][LW-1:0]), DW'(lit2[i]));
    check("eight_beat_latency", DW'(first_vld_cyc - first_acc_cyc), DW'(2));
    check("eight_beat_stat_beats", DW'(stat_beats), DW'(8));

    // Random backpressure, no embedding
    ready_mode = 1;
    start_job($urandom, $urandom, 32'd0);
    send_beats(256, 0, 1'b1, 20);
    wait_done("random");
    check("random_count", DW'(out_log.size()), DW'(256));
    check("random_stat_beats", DW'(stat_beats), DW'(256));
    check("random_checksum", DW'(stat_checksum), DW'(exp_csum));
    check("random_queue_empty", DW'(exp_q.size()), '0);
    ready_mode = 0;

    // Beats offered while idle must be refused
    s_if.tvalid = 1'b1; s_if.tdata = gen_data(0, 0); s_if.tlast = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      check("idle_tready", DW'(s_if.tready), '0);
    end
    @(posedge aclk); #1;
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;

    // Second ap_start mid-job is ignored
    ready_mode = 1;
    start_job($urandom, $urandom, 32'd3);
    d0 = done_cnt;
    fork
      send_beats(6, 0, 1'b1, 10);
      begin
        repeat (3) @(posedge aclk);
        #1 ap_start = 1'b1;
        @(posedge aclk); #1 ap_start = 1'b0;
      end
    join
    wait_done("restart");
    repeat (4) @(posedge aclk); #1;
    check("restart_done_once", DW'(done_cnt - d0), DW'(1));
    check("restart_stat_beats", DW'(stat_beats), DW'(6));
    check("restart_checksum", DW'(stat_checksum), DW'(exp_csum));
    ready_mode = 0;

    // Reset with two beats in flight
    ready_mode = 2;
    @(posedge aclk); #1;
    start_job($urandom, $urandom, 32'd2);
    send_beats(2, 0, 1'b0, 0);
    check("pipe_full_valid", DW'(m_if.tvalid), DW'(1));
    d0 = done_cnt;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    exp_q.delete();
    check_reset_values("mid_reset");
    ready_mode = 0;
    start_job($urandom, $urandom, 32'd2);
    send_beats(3, 0, 1'b1, 0);
    wait_done("post_reset");
    check("post_reset_stat_beats", DW'(stat_beats), DW'(3));
    check("post_reset_checksum", DW'(stat_checksum), DW'(exp_csum));

    // Back-to-back jobs
    start_job($urandom, $urandom, 32'd5);
    send_beats(7, 0, 1'b1, 0);
    wait_done("b2b_a");
    while (!ap_idle) begin @(posedge aclk); #1; end
    start_job(32'h1000_0001, 32'h0F0F_0F0F, 32'd1);
    send_beats(4, 0, 1'b1, 0);
    wait_done("b2b_b");
    check("b2b_stat_beats", DW'(stat_beats), DW'(4));
    check("b2b_checksum", DW'(stat_checksum), DW'(exp_csum));
    check("b2b_queue_empty", DW'(exp_q.size()), '0);

    repeat (5) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
